// File: rtl/tinycpu_pkg.sv
// Shared tinycpu definitions: default widths, ALU result op codes and
// result-queue occupancy encodings.
package tinycpu_pkg;

    localparam int DATA_W = 8;
    localparam int DEST_W = 2;

    localparam logic [2:0] OP_OUT0 = 3'd0;
    localparam logic [2:0] OP_OUT1 = 3'd1;
    localparam logic [2:0] OP_OUT2 = 3'd2;
    localparam logic [2:0] OP_OUT3 = 3'd3;
    localparam logic [2:0] OP_OUT4 = 3'd4;
    localparam logic [2:0] OP_OUT5 = 3'd5;
    localparam logic [2:0] OP_OUT6 = 3'd6;
    localparam logic [2:0] OP_OUT7 = 3'd7;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

endpackage

// File: rtl/alu_out_mux.sv
// Combinational 8:1 select of one ALU result bus by op code.
module alu_out_mux #(
    parameter int DATA_W = tinycpu_pkg::DATA_W
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] out0,
    input  logic [DATA_W-1:0] out1,
    input  logic [DATA_W-1:0] out2,
    input  logic [DATA_W-1:0] out3,
    input  logic [DATA_W-1:0] out4,
    input  logic [DATA_W-1:0] out5,
    input  logic [DATA_W-1:0] out6,
    input  logic [DATA_W-1:0] out7,
    output logic [DATA_W-1:0] sel
);
    import tinycpu_pkg::*;

    always_comb begin
        sel = out0;
        case (op)
            OP_OUT1: sel = out1;
            OP_OUT2: sel = out2;
            OP_OUT3: sel = out3;
            OP_OUT4: sel = out4;
            OP_OUT5: sel = out5;
            OP_OUT6: sel = out6;
            OP_OUT7: sel = out7;
            default: sel = out0;
        endcase
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: picks one result per op, queues it in a 2-entry buffer
// toward writeback, and tracks zero/negative flags plus a commit counter.
module alu_result_stage #(
    parameter int DATA_W = tinycpu_pkg::DATA_W,
    parameter int DEST_W = tinycpu_pkg::DEST_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        op,
    input  logic [DEST_W-1:0] dest,
    input  logic [DATA_W-1:0] out0,
    input  logic [DATA_W-1:0] out1,
    input  logic [DATA_W-1:0] out2,
    input  logic [DATA_W-1:0] out3,
    input  logic [DATA_W-1:0] out4,
    input  logic [DATA_W-1:0] out5,
    input  logic [DATA_W-1:0] out6,
    input  logic [DATA_W-1:0] out7,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [DEST_W-1:0] wb_dest,
    output logic              flag_z,
    output logic              flag_n,
    output logic [CNT_W-1:0]  commit_cnt
);
    import tinycpu_pkg::*;

    logic [1:0]        count_reg;
    logic [DATA_W-1:0] slot0_data_reg;
    logic [DEST_W-1:0] slot0_dest_reg;
    logic [DATA_W-1:0] slot1_data_reg;
    logic [DEST_W-1:0] slot1_dest_reg;
    logic              flag_z_reg;
    logic              flag_n_reg;
    logic [CNT_W-1:0]  commit_cnt_reg;

    logic [DATA_W-1:0] sel_data;
    logic              push;
    logic              pop;

    alu_out_mux #(.DATA_W(DATA_W)) u_mux (
        .op   (op),
        .out0 (out0),
        .out1 (out1),
        .out2 (out2),
        .out3 (out3),
        .out4 (out4),
        .out5 (out5),
        .out6 (out6),
        .out7 (out7),
        .sel  (sel_data)
    );

    // Ready depends only on occupancy and reset, never on wb_ready.
    assign in_ready = !rst && (count_reg != ST_FULL);
    assign wb_valid = (count_reg != ST_EMPTY);
    assign push     = in_valid && in_ready;
    assign pop      = wb_valid && wb_ready;

    // slot0 is always the head; slot1 only ever holds the younger entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg      <= ST_EMPTY;
            slot0_data_reg <= '0;
            slot0_dest_reg <= '0;
            slot1_data_reg <= '0;
            slot1_dest_reg <= '0;
        end else begin
            case (count_reg)
                ST_EMPTY: begin
                    if (push) begin
                        slot0_data_reg <= sel_data;
                        slot0_dest_reg <= dest;
                        count_reg      <= ST_HALF;
                    end
                end
                ST_HALF: begin
                    if (push && pop) begin
                        slot0_data_reg <= sel_data;
                        slot0_dest_reg <= dest;
                    end else if (push) begin
                        slot1_data_reg <= sel_data;
                        slot1_dest_reg <= dest;
                        count_reg      <= ST_FULL;
                    end else if (pop) begin
                        count_reg <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        slot0_data_reg <= slot1_data_reg;
                        slot0_dest_reg <= slot1_dest_reg;
                        count_reg      <= ST_HALF;
                    end
                end
                default: count_reg <= ST_EMPTY;
            endcase
        end
    end

    // Flags and counter describe the committed head, so they move only on pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z_reg     <= 1'b0;
            flag_n_reg     <= 1'b0;
            commit_cnt_reg <= '0;
        end else if (pop) begin
            flag_z_reg     <= (slot0_data_reg == '0);
            flag_n_reg     <= slot0_data_reg[DATA_W-1];
            commit_cnt_reg <= commit_cnt_reg + 1'b1;
        end
    end

    assign wb_data    = slot0_data_reg;
    assign wb_dest    = slot0_dest_reg;
    assign flag_z     = flag_z_reg;
    assign flag_n     = flag_n_reg;
    assign commit_cnt = commit_cnt_reg;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed scenarios plus random
// traffic compared against a queue-based model of the result stage.
module tb_alu_result_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  op;
    logic [1:0]  dest;
    logic [7:0]  outs [8];
    logic        wb_valid;
    logic        wb_ready;
    logic [7:0]  wb_data;
    logic [1:0]  wb_dest;
    logic        flag_z;
    logic        flag_n;
    logic [15:0] commit_cnt;

    alu_result_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .dest       (dest),
        .out0       (outs[0]),
        .out1       (outs[1]),
        .out2       (outs[2]),
        .out3       (outs[3]),
        .out4       (outs[4]),
        .out5       (outs[5]),
        .out6       (outs[6]),
        .out7       (outs[7]),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_dest    (wb_dest),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .commit_cnt (commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] dest;
    } entry_t;

    entry_t      m_q [$];
    logic        m_z;
    logic        m_n;
    logic [15:0] m_cnt;
    int          total;
    int          bad;
    bit          verbose;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("wb_valid", 32'(wb_valid), 32'(m_q.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(m_q.size() != 2));
        if (m_q.size() != 0) begin
            chk("wb_data", 32'(wb_data), 32'(m_q[0].data));
            chk("wb_dest", 32'(wb_dest), 32'(m_q[0].dest));
        end
        chk("flag_z", 32'(flag_z), 32'(m_z));
        chk("flag_n", 32'(flag_n), 32'(m_n));
        chk("commit_cnt", 32'(commit_cnt), 32'(m_cnt));
    endtask

    // One clock: drive at negedge, check before the edge, advance the model.
    task automatic step(input logic iv, input logic [2:0] o, input logic [1:0] d, input logic wr);
        bit     do_push;
        bit     do_pop;
        entry_t nw;
        entry_t hd;
        in_valid = iv;
        op       = o;
        dest     = d;
        wb_ready = wr;
        #1;
        check_model();
        do_push = iv && (m_q.size() < 2);
        do_pop  = wr && (m_q.size() > 0);
        nw.data = outs[o];
        nw.dest = d;
        @(posedge clk);
        if (do_pop) begin
            hd    = m_q.pop_front();
            m_z   = (hd.data == 8'd0);
            m_n   = hd.data[7];
            m_cnt = m_cnt + 16'd1;
            if (verbose) $display("txn pop  data=%02h dest=%0d cnt=%0d", hd.data, hd.dest, m_cnt);
        end
        if (do_push) begin
            m_q.push_back(nw);
            if (verbose) $display("txn push data=%02h dest=%0d op=%0d", nw.data, nw.dest, o);
        end
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_q.delete();
        m_z   = 1'b0;
        m_n   = 1'b0;
        m_cnt = 16'd0;
    endtask

    initial begin
        int guard;
        total    = 0;
        bad      = 0;
        verbose  = 1'b1;
        rst      = 1'b1;
        in_valid = 1'b0;
        op       = 3'd0;
        dest     = 2'd0;
        wb_ready = 1'b0;
        for (int i = 0; i < 8; i++) outs[i] = 8'h00;
        model_reset();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_wb_data", 32'(wb_data), 32'd0);
        chk("rst_wb_dest", 32'(wb_dest), 32'd0);
        chk("rst_cnt", 32'(commit_cnt), 32'd0);
        rst = 1'b0;

        // Single op
        outs[0] = 8'h0B;
        outs[1] = 8'hFF;
        step(1'b1, 3'd0, 2'd2, 1'b1);
        chk("single_data", 32'(wb_data), 32'h0B);
        chk("single_dest", 32'(wb_dest), 32'd2);
        step(1'b0, 3'd0, 2'd0, 1'b1);
        chk("single_z", 32'(flag_z), 32'd0);
        chk("single_n", 32'(flag_n), 32'd0);
        chk("single_cnt", 32'(commit_cnt), 32'd1);

        // Flag values, including push/pop overlap in HALF
        outs[3] = 8'h00;
        outs[1] = 8'h80;
        step(1'b1, 3'd3, 2'd1, 1'b1);
        step(1'b1, 3'd1, 2'd0, 1'b1);
        chk("flag1_z", 32'(flag_z), 32'd1);
        chk("flag1_n", 32'(flag_n), 32'd0);
        step(1'b0, 3'd0, 2'd0, 1'b1);
        chk("flag2_z", 32'(flag_z), 32'd0);
        chk("flag2_n", 32'(flag_n), 32'd1);

        // Backpressure and full
        outs[0] = 8'h11;
        step(1'b1, 3'd0, 2'd1, 1'b0);
        outs[0] = 8'h22;
        step(1'b1, 3'd0, 2'd3, 1'b0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_hold", 32'(wb_data), 32'h11);
        outs[0] = 8'h33;
        step(1'b1, 3'd0, 2'd0, 1'b0);
        chk("full_hold2", 32'(wb_data), 32'h11);
        step(1'b0, 3'd0, 2'd0, 1'b1);
        chk("drain_data", 32'(wb_data), 32'h22);
        chk("drain_ready", 32'(in_ready), 32'd1);
        step(1'b0, 3'd0, 2'd0, 1'b1);
        chk("drain_empty", 32'(wb_valid), 32'd0);
        chk("drain_cnt", 32'(commit_cnt), 32'd5);

        // Streaming with op cycling through all codes
        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 8; j++) outs[j] = 8'($urandom);
            step(1'b1, 3'(i), 2'(i), 1'b1);
        end

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            for (int j = 0; j < 8; j++) outs[j] = 8'($urandom);
            if ((i % 50) == 7) outs[$urandom_range(0, 7)] = 8'h00;
            step(1'($urandom_range(0, 9) < 7), 3'($urandom), 2'($urandom),
                 1'($urandom_range(0, 9) < 6));
        end

        // Reset with two entries buffered
        while (m_q.size() != 0) step(1'b0, 3'd0, 2'd0, 1'b1);
        outs[5] = 8'hA5;
        step(1'b1, 3'd5, 2'd1, 1'b0);
        step(1'b1, 3'd5, 2'd2, 1'b0);
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(wb_valid), 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_z", 32'(flag_z), 32'd0);
        chk("mid_rst_n", 32'(flag_n), 32'd0);
        chk("mid_rst_cnt", 32'(commit_cnt), 32'd0);
        model_reset();
        in_valid = 1'b1;
        wb_ready = 1'b1;
        @(negedge clk);
        chk("rst_hold_ready", 32'(in_ready), 32'd0);
        chk("rst_hold_valid", 32'(wb_valid), 32'd0);
        rst = 1'b0;
        step(1'b0, 3'd0, 2'd0, 1'b1);
        step(1'b0, 3'd0, 2'd0, 1'b1);

        // Counter wrap through continuous commits
        verbose = 1'b0;
        guard = 0;
        outs[2] = 8'h5A;
        while (m_cnt != 16'hFFFF && guard < 70000) begin
            step(1'b1, 3'd2, 2'd3, 1'b1);
            guard++;
        end
        chk("wrap_reached", 32'(m_cnt), 32'hFFFF);
        chk("wrap_pre", 32'(commit_cnt), 32'hFFFF);
        step(1'b0, 3'd0, 2'd0, 1'b1);
        chk("wrap_zero", 32'(commit_cnt), 32'h0000);
        step(1'b0, 3'd0, 2'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
